// File: rtl/dht11_responder_if.sv
// Bus bundle between a DHT11 host (or bench) and the sensor-side responder.
// The host side owns the bytes, the enable and the sampled bus level; the responder owns the pull-down.
interface dht11_responder_if;
    logic       en;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] tmp_int;
    logic [7:0] tmp_dec;
    logic       dq_in;
    logic       dq_oe;
    logic       busy;
    logic       done;
    logic       short_start;

    modport master (
        output en, hum_int, hum_dec, tmp_int, tmp_dec, dq_in,
        input  dq_oe, busy, done, short_start
    );

    modport slave (
        input  en, hum_int, hum_dec, tmp_int, tmp_dec, dq_in,
        output dq_oe, busy, done, short_start
    );
endinterface

// File: rtl/dht11_responder.sv
// DHT11 sensor emulator: qualifies the host start pulse, answers with the presence
// sequence and shifts out 40 data bits (4 bytes plus checksum) on an open-drain line.
module dht11_responder #(
    parameter int CLK_PER_US   = 100,
    parameter int START_MIN_US = 18000,
    parameter int RESP_DLY_US  = 30,
    parameter int RESP_US      = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HI_US   = 27,
    parameter int BIT1_HI_US   = 70
) (
    input  logic              clk,
    input  logic              rst,
    dht11_responder_if.slave  bus
);

    localparam logic [20:0] START_CYC = 21'(START_MIN_US * CLK_PER_US);
    localparam logic [20:0] DLY_LAST  = 21'(RESP_DLY_US * CLK_PER_US - 1);
    localparam logic [20:0] RESP_LAST = 21'(RESP_US * CLK_PER_US - 1);
    localparam logic [20:0] BLOW_LAST = 21'(BIT_LOW_US * CLK_PER_US - 1);
    localparam logic [20:0] B0_LAST   = 21'(BIT0_HI_US * CLK_PER_US - 1);
    localparam logic [20:0] B1_LAST   = 21'(BIT1_HI_US * CLK_PER_US - 1);
    localparam logic [20:0] CNT_MAX   = 21'h1F_FFFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_LOW = 3'd1,
        RESP_DLY  = 3'd2,
        RESP_LOW  = 3'd3,
        RESP_HIGH = 3'd4,
        BIT_LOW   = 3'd5,
        BIT_HIGH  = 3'd6,
        END_LOW   = 3'd7
    } state_t;

    // 8-bit sum of the four payload bytes; carries out of bit 7 are dropped.
    function automatic logic [7:0] dht_chk(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
        logic [7:0] sum;
        sum = a + b;
        sum = sum + c;
        sum = sum + d;
        return sum;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [1:0]  sync_r;
    logic        dq_d_r;
    logic        dq_s;
    logic        fall_s;
    logic        rise_s;
    logic [20:0] cnt_r;
    logic [39:0] shreg_r;
    logic [5:0]  idx_r;
    logic        oe_r;
    logic        busy_r;
    logic        done_r;
    logic        short_r;
    logic        load_s;
    logic        shift_s;
    logic        short_s;
    logic        done_s;
    logic        oe_s;
    logic        busy_s;

    assign dq_s   = sync_r[1];
    assign fall_s = dq_d_r & ~dq_s;
    assign rise_s = ~dq_d_r & dq_s;

    // Two-flop synchroniser for the raw bus level plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= 2'b11;
            dq_d_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], bus.dq_in};
            dq_d_r <= sync_r[1];
        end
    end

    // Next-state and output decode; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        shift_s = 1'b0;
        short_s = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.en && fall_s) begin
                    state_s = START_LOW;
                end else begin
                    state_s = IDLE;
                end
            end
            START_LOW: begin
                // A saturated counter still reads as >= START_CYC, so very long starts are accepted.
                if (rise_s) begin
                    if (cnt_r >= START_CYC) begin
                        state_s = RESP_DLY;
                        load_s  = 1'b1;
                    end else begin
                        state_s = IDLE;
                        short_s = 1'b1;
                    end
                end else begin
                    state_s = START_LOW;
                end
            end
            RESP_DLY: begin
                if (cnt_r == DLY_LAST) begin
                    state_s = RESP_LOW;
                end else begin
                    state_s = RESP_DLY;
                end
            end
            RESP_LOW: begin
                if (cnt_r == RESP_LAST) begin
                    state_s = RESP_HIGH;
                end else begin
                    state_s = RESP_LOW;
                end
            end
            RESP_HIGH: begin
                if (cnt_r == RESP_LAST) begin
                    state_s = BIT_LOW;
                end else begin
                    state_s = RESP_HIGH;
                end
            end
            BIT_LOW: begin
                if (cnt_r == BLOW_LAST) begin
                    state_s = BIT_HIGH;
                end else begin
                    state_s = BIT_LOW;
                end
            end
            BIT_HIGH: begin
                if (cnt_r == (shreg_r[39] ? B1_LAST : B0_LAST)) begin
                    shift_s = 1'b1;
                    if (idx_r == 6'd39) begin
                        state_s = END_LOW;
                    end else begin
                        state_s = BIT_LOW;
                    end
                end else begin
                    state_s = BIT_HIGH;
                end
            end
            END_LOW: begin
                if (cnt_r == BLOW_LAST) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                end else begin
                    state_s = END_LOW;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        oe_s   = (state_s == RESP_LOW) || (state_s == BIT_LOW) || (state_s == END_LOW);
        busy_s = (state_s != IDLE);
    end

    // State, phase counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= 21'd0;
            oe_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            short_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                cnt_r <= 21'd0;
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + 21'd1;
            end else begin
                cnt_r <= cnt_r;
            end
            oe_r    <= oe_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            short_r <= short_s;
        end
    end

    // Frame shift register: snapshotted when the start is accepted so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg_r <= 40'd0;
            idx_r   <= 6'd0;
        end else if (load_s) begin
            shreg_r <= {bus.hum_int, bus.hum_dec, bus.tmp_int, bus.tmp_dec,
                        dht_chk(bus.hum_int, bus.hum_dec, bus.tmp_int, bus.tmp_dec)};
            idx_r   <= 6'd0;
        end else if (shift_s) begin
            shreg_r <= {shreg_r[38:0], 1'b0};
            idx_r   <= idx_r + 6'd1;
        end else begin
            shreg_r <= shreg_r;
            idx_r   <= idx_r;
        end
    end

    assign bus.dq_oe       = oe_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.short_start = short_r;

endmodule

// File: tb/tb_dht11_responder.sv
// Scoreboard bench for dht11_responder: a host model issues start pulses and queues the
// expected outcome, while a bus monitor decodes pulse widths and checks on done/short_start.
module tb_dht11_responder;

    localparam int CPU     = 1;
    localparam int SMIN    = 300;
    localparam int PRES    = 80 * CPU;
    localparam int BLOW    = 50 * CPU;
    localparam int HI0     = 27 * CPU;
    localparam int HI1     = 70 * CPU;

    typedef enum int {K_FRAME = 0, K_SHORT = 1, K_ABORT = 2} kind_t;
    typedef struct {
        kind_t       kind;
        logic [39:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic host_low = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   unexpected = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    dht11_responder_if bus();
    assign bus.dq_in = ~(host_low | bus.dq_oe);

    dht11_responder #(.CLK_PER_US(CPU), .START_MIN_US(SMIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the four bytes in order, then their 8-bit sum.
    function automatic logic [39:0] ref_frame(input logic [7:0] h, input logic [7:0] hd,
                                              input logic [7:0] t, input logic [7:0] td);
        int s;
        s = (int'(h) + int'(hd) + int'(t) + int'(td)) % 256;
        return {h, hd, t, td, 8'(s)};
    endfunction

    // ---------------- monitor ----------------
    logic        rst_at_pos = 1'b1;
    logic        in_rst = 1'b0;
    logic        prev_oe = 1'b0;
    logic        prev_busy = 1'b0;
    int          pulses = 0;
    int          lo_run = 0;
    int          hi_run = 0;
    int          bits_seen = 0;
    int          tim_err = 0;
    logic [39:0] bits = 40'd0;
    exp_t        me;

    always @(posedge clk) rst_at_pos <= rst;

    always @(negedge clk) begin
        if (!rst_at_pos) begin
            if (!in_rst) begin
                in_rst = 1'b1;
                check("reset_outputs", 64'({bus.dq_oe, bus.busy, bus.done, bus.short_start}), 64'd0);
                if (q.size() > 0 && q[0].kind == K_ABORT) begin
                    void'(q.pop_front());
                    check("abort_was_midframe", 64'(prev_busy), 64'd1);
                end
            end
            pulses = 0; bits_seen = 0; tim_err = 0; bits = 40'd0;
            prev_oe = 1'b0; prev_busy = 1'b0;
        end else begin
            in_rst = 1'b0;
            if (bus.busy && !prev_busy && q.size() == 0) unexpected++;
            if (bus.dq_oe && !prev_oe) begin
                if (q.size() == 0 || q[0].kind == K_SHORT) unexpected++;
                if (pulses == 1 && hi_run != PRES) tim_err++;
                if (pulses >= 2) begin
                    bits_seen++;
                    if (hi_run == HI1) bits = {bits[38:0], 1'b1};
                    else begin
                        bits = {bits[38:0], 1'b0};
                        if (hi_run != HI0) tim_err++;
                    end
                end
                pulses++;
                lo_run = 1;
            end else if (!bus.dq_oe && prev_oe) begin
                if (lo_run != ((pulses == 1) ? PRES : BLOW)) tim_err++;
                hi_run = 1;
            end else if (bus.dq_oe) begin
                lo_run++;
            end else begin
                hi_run++;
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL done_unexpected: got done with empty queue (t=%0t)", $time);
                end else begin
                    me = q.pop_front();
                    check("done_kind", 64'(int'(me.kind)), 64'(int'(K_FRAME)));
                    check("frame_bits", 64'(bits), 64'(me.data));
                    check("pulse_count", 64'(pulses), 64'd42);
                    check("bits_seen", 64'(bits_seen), 64'd40);
                    check("timing_errors", 64'(tim_err), 64'd0);
                    check("busy_at_done", 64'(bus.busy), 64'd0);
                end
                pulses = 0; bits_seen = 0; tim_err = 0; bits = 40'd0;
            end
            if (bus.short_start) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL short_unexpected: got short_start with empty queue (t=%0t)", $time);
                end else begin
                    me = q.pop_front();
                    check("short_kind", 64'(int'(me.kind)), 64'(int'(K_SHORT)));
                    check("short_no_drive", 64'(pulses), 64'd0);
                    check("busy_at_short", 64'(bus.busy), 64'd0);
                end
                pulses = 0; bits_seen = 0; tim_err = 0; bits = 40'd0;
            end
            prev_oe = bus.dq_oe;
            prev_busy = bus.busy;
        end
    end

    // ---------------- stimulus ----------------
    task automatic host_start(input int len);
        @(posedge clk); #1 host_low = 1'b1;
        repeat (len) @(posedge clk);
        #1 host_low = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++; failures++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
        end
    endtask

    task automatic set_bytes(input logic [7:0] h, input logic [7:0] hd,
                             input logic [7:0] t, input logic [7:0] td);
        bus.hum_int = h; bus.hum_dec = hd; bus.tmp_int = t; bus.tmp_dec = td;
    endtask

    task automatic push(input kind_t k, input logic [39:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic do_frame(input logic [7:0] h, input logic [7:0] hd,
                            input logic [7:0] t, input logic [7:0] td);
        set_bytes(h, hd, t, td);
        push(K_FRAME, ref_frame(h, hd, t, td));
        host_start(SMIN + int'($urandom_range(5, 60)));
        wait_idle("frame_done_timeout", 6000);
        repeat (30) @(posedge clk);
    endtask

    initial begin
        int n;
        int seen;
        logic p;
        bus.en = 1'b1;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);

        do_frame(8'h37, 8'h00, 8'h19, 8'h05);
        do_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);

        push(K_SHORT, 40'd0);
        host_start(SMIN - int'($urandom_range(20, 200)));
        wait_idle("short_timeout", 50);
        repeat (30) @(posedge clk);

        for (int i = 0; i < 3; i++)
            do_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Disabled responder must ignore a valid start entirely.
        bus.en = 1'b0;
        host_start(SMIN + 20);
        repeat (5200) @(posedge clk);
        bus.en = 1'b1;
        do_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Payload change after the start is accepted must not reach the frame.
        set_bytes(8'h37, 8'h00, 8'h19, 8'h05);
        push(K_FRAME, ref_frame(8'h37, 8'h00, 8'h19, 8'h05));
        host_start(SMIN + 10);
        n = 0;
        @(negedge clk);
        while (!bus.dq_oe && n < 200) begin @(negedge clk); n++; end
        if (!bus.dq_oe) begin
            checks++; failures++;
            $display("FAIL presence_timeout: dq_oe 0 after 200 cycles, expected 1");
        end
        bus.hum_int = 8'h40;
        wait_idle("frame_done_timeout", 6000);
        repeat (30) @(posedge clk);

        // Reset in the middle of bit 12, then a clean frame.
        set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        push(K_ABORT, 40'd0);
        host_start(SMIN + 10);
        n = 0; seen = 0; p = 1'b0;
        while (seen < 14 && n < 3000) begin
            @(negedge clk);
            n++;
            if (bus.dq_oe && !p) seen++;
            p = bus.dq_oe;
        end
        if (seen < 14) begin
            checks++; failures++;
            $display("FAIL abort_setup: saw %0d pulses, expected 14", seen);
        end
        repeat (10) @(negedge clk);
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (20) @(posedge clk);
        do_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        repeat (20) @(posedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        check("unexpected_activity", 64'(unexpected), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
